// File: rtl/serial_code_decoder.sv
// Serial receiver for the 4-bit code link: shifts in MSB-first code words,
// applies the inverse code conversion and presents the result on a valid/ready port.
module serial_code_decoder #(
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         sin,
    input  logic         sin_valid,
    output logic         sin_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_err,
    output logic         busy,
    output logic         abort
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    mode_reg;
    logic [W-2:0]  shreg;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle_cnt;
    logic [W-1:0]  word_reg;
    logic          err_reg;
    logic          abort_reg;
    logic          accept;
    logic          last_bit;
    logic          timeout_hit;
    logic [W:0]    conv;

    function automatic logic [W:0] convert(input logic [1:0] m, input logic [W-1:0] x);
        logic [W-1:0] y;
        logic         err;
        logic [3:0]   d;
        y   = '0;
        err = 1'b0;
        d   = '0;
        case (m)
            2'b00: begin
                y[W-1] = x[W-1];
                for (int unsigned k = 1; k < W; k++)
                    y[W-1-k] = y[W-k] ^ x[W-1-k];
            end
            2'b01: begin
                for (int unsigned g = 0; g < W / 4; g++) begin
                    d = x[4*g +: 4];
                    if (d < 4'd3 || d > 4'd12) err = 1'b1;
                    y[4*g +: 4] = d - 4'd3;
                end
            end
            2'b10: y = x ^ (x >> 1);
            default: begin
                for (int unsigned g = 0; g < W / 4; g++) begin
                    d = x[4*g +: 4];
                    if (d > 4'd9) err = 1'b1;
                    y[4*g +: 4] = d + 4'd3;
                end
            end
        endcase
        if (err) y = '0;
        return {err, y};
    endfunction

    assign accept      = sin_valid && (state != OUT) && !rst;
    assign last_bit    = accept && (state == SHIFT) && (cnt == CNT_LAST);
    // An accepted bit always beats an expiring idle counter.
    assign timeout_hit = (TIMEOUT != 0) && (state == SHIFT) && !accept && (idle_cnt == IDLE_LAST);
    assign conv        = convert(mode_reg, {shreg, sin});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT: begin
                if (last_bit)         next_state = OUT;
                else if (timeout_hit) next_state = IDLE;
            end
            OUT:     if (dout_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg  <= '0;
            shreg     <= '0;
            cnt       <= '0;
            idle_cnt  <= '0;
            word_reg  <= '0;
            err_reg   <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            abort_reg <= timeout_hit;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_reg <= mode;
                        shreg    <= {shreg[W-3:0], sin};
                        cnt      <= CW'(1);
                        idle_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shreg    <= {shreg[W-3:0], sin};
                        cnt      <= cnt + CW'(1);
                        idle_cnt <= '0;
                        if (last_bit) begin
                            word_reg <= conv[W-1:0];
                            err_reg  <= conv[W];
                        end
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sin_ready  = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
        abort      = 1'b0;
        dout       = '0;
        dout_err   = 1'b0;
        if (!rst) begin
            sin_ready  = (state != OUT);
            dout_valid = (state == OUT);
            busy       = (state != IDLE);
            abort      = abort_reg;
            dout       = word_reg;
            dout_err   = err_reg;
        end
    end

endmodule

// File: tb/tb_serial_code_decoder.sv
// Directed bench for serial_code_decoder: W=4 table-driven frames plus
// hand-written backpressure, timeout, reset and W=8 sequences.
module tb_serial_code_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       sin, sin_valid, sin_ready;
    logic [3:0] dout;
    logic       dout_valid, dout_ready, dout_err, busy, abort;

    logic [1:0] mode8;
    logic       sin8, sin_valid8, sin_ready8;
    logic [7:0] dout8;
    logic       dout_valid8, dout_ready8, dout_err8, busy8, abort8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_code_decoder #(.W(4), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sin(sin), .sin_valid(sin_valid),
        .sin_ready(sin_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_err(dout_err), .busy(busy), .abort(abort)
    );

    serial_code_decoder #(.W(8), .TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .sin(sin8), .sin_valid(sin_valid8),
        .sin_ready(sin_ready8), .dout(dout8), .dout_valid(dout_valid8),
        .dout_ready(dout_ready8), .dout_err(dout_err8), .busy(busy8), .abort(abort8)
    );

    typedef struct {
        logic [1:0] m;
        logic [3:0] bits;
        logic [3:0] y;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send4(input logic [1:0] m, input logic [3:0] bits);
        logic [3:0] b;
        b = bits;
        for (int unsigned k = 0; k < 4; k++) begin
            mode      = m;
            sin       = b[3-k];
            sin_valid = 1'b1;
            @(posedge clk); #1;
            if (k != 3) check("early_valid", dout_valid, 0);
        end
        sin_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_ab;
        int n_v;
        int first_ab;
        logic [7:0] w8 [2];
        logic [7:0] y8 [2];
        logic       e8 [2];
        logic [7:0] x8;

        vecs[0]  = '{2'b00, 4'b1101, 4'b1001, 1'b0};
        vecs[1]  = '{2'b01, 4'b1100, 4'b1001, 1'b0};
        vecs[2]  = '{2'b01, 4'b0010, 4'b0000, 1'b1};
        vecs[3]  = '{2'b11, 4'b0111, 4'b1010, 1'b0};
        vecs[4]  = '{2'b10, 4'b0110, 4'b0101, 1'b0};
        vecs[5]  = '{2'b01, 4'b0011, 4'b0000, 1'b0};
        vecs[6]  = '{2'b01, 4'b1101, 4'b0000, 1'b1};
        vecs[7]  = '{2'b11, 4'b1001, 4'b1100, 1'b0};
        vecs[8]  = '{2'b11, 4'b1010, 4'b0000, 1'b1};
        vecs[9]  = '{2'b10, 4'b1111, 4'b1000, 1'b0};
        vecs[10] = '{2'b00, 4'b1000, 4'b1111, 1'b0};
        vecs[11] = '{2'b01, 4'b1111, 4'b0000, 1'b1};
        w8[0] = 8'h4C; y8[0] = 8'h19; e8[0] = 1'b0;
        w8[1] = 8'h2C; y8[1] = 8'h00; e8[1] = 1'b1;

        rst = 1'b1; mode = '0; sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b1;
        mode8 = '0; sin8 = 1'b0; sin_valid8 = 1'b0; dout_ready8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_sin_ready", sin_ready, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        check("rst_dout", dout, 0);
        check("rst_err", dout_err, 0);
        check("rst_sin_ready8", sin_ready8, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", sin_ready, 1);

        for (int unsigned i = 0; i < 12; i++) begin
            send4(vecs[i].m, vecs[i].bits);
            check("vec_valid", dout_valid, 1);
            check("vec_dout", dout, vecs[i].y);
            check("vec_err", dout_err, vecs[i].err);
            check("vec_busy", busy, 1);
            @(posedge clk); #1;
            check("vec_valid_1cyc", dout_valid, 0);
            check("vec_ready_back", sin_ready, 1);
        end

        // mode changes after the first bit are ignored
        mode = 2'b11; sin = 1'b0; sin_valid = 1'b1;
        @(posedge clk); #1;
        mode = 2'b00;
        for (int unsigned k = 0; k < 3; k++) begin
            sin = 1'b1;
            @(posedge clk); #1;
        end
        sin_valid = 1'b0;
        check("toggle_valid", dout_valid, 1);
        check("toggle_dout", dout, 4'b1010);
        check("toggle_err", dout_err, 0);
        @(posedge clk); #1;

        // backpressure
        dout_ready = 1'b0;
        send4(2'b11, 4'b0111);
        for (int unsigned k = 0; k < 5; k++) begin
            sin_valid = 1'b1; sin = 1'b1;
            @(posedge clk); #1;
            check("bp_valid", dout_valid, 1);
            check("bp_dout", dout, 4'b1010);
            check("bp_sin_ready", sin_ready, 0);
        end
        sin_valid = 1'b0; dout_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released", dout_valid, 0);
        check("bp_ready_back", sin_ready, 1);
        send4(2'b00, 4'b1101);
        check("bp_next_valid", dout_valid, 1);
        check("bp_next_dout", dout, 4'b1001);
        @(posedge clk); #1;

        // timeout abort after 2 bits
        mode = 2'b00; sin_valid = 1'b1;
        sin = 1'b1; @(posedge clk); #1;
        sin = 1'b0; @(posedge clk); #1;
        sin_valid = 1'b0;
        n_ab = 0; n_v = 0; first_ab = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (abort) begin
                n_ab++;
                if (first_ab < 0) first_ab = k;
            end
            if (dout_valid) n_v++;
        end
        check("to_abort_count", n_ab, 1);
        check("to_abort_cycle", first_ab, 7);
        check("to_no_valid", n_v, 0);
        check("to_busy", busy, 0);
        send4(2'b01, 4'b1100);
        check("to_next_valid", dout_valid, 1);
        check("to_next_dout", dout, 4'b1001);
        @(posedge clk); #1;

        // bit accepted on the cycle the timeout would fire
        mode = 2'b10; sin_valid = 1'b1;
        sin = 1'b0; @(posedge clk); #1;
        sin = 1'b1; @(posedge clk); #1;
        sin_valid = 1'b0;
        n_ab = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (abort) n_ab++;
        end
        sin_valid = 1'b1;
        sin = 1'b1; @(posedge clk); #1;
        if (abort) n_ab++;
        sin = 1'b0; @(posedge clk); #1;
        if (abort) n_ab++;
        sin_valid = 1'b0;
        check("race_no_abort", n_ab, 0);
        check("race_valid", dout_valid, 1);
        check("race_dout", dout, 4'b0101);
        @(posedge clk); #1;

        // reset after the third bit
        mode = 2'b00; sin_valid = 1'b1;
        sin = 1'b1; @(posedge clk); #1;
        sin = 1'b1; @(posedge clk); #1;
        sin = 1'b0; @(posedge clk); #1;
        sin_valid = 1'b0; rst = 1'b1;
        #1;
        check("rstmid_busy_comb", busy, 0);
        check("rstmid_ready_comb", sin_ready, 0);
        @(posedge clk); #1;
        check("rstmid_valid", dout_valid, 0);
        rst = 1'b0;
        send4(2'b00, 4'b1101);
        check("rstmid_next_valid", dout_valid, 1);
        check("rstmid_next_dout", dout, 4'b1001);
        @(posedge clk); #1;

        // reset while an output is pending
        dout_ready = 1'b0;
        send4(2'b10, 4'b0110);
        rst = 1'b1;
        #1;
        check("rstout_valid_comb", dout_valid, 0);
        check("rstout_dout_comb", dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rstout_discarded", dout_valid, 0);
        check("rstout_ready", sin_ready, 1);
        dout_ready = 1'b1;

        // W=8 XS3->BCD
        for (int unsigned v = 0; v < 2; v++) begin
            x8 = w8[v];
            mode8 = 2'b01;
            for (int unsigned k = 0; k < 8; k++) begin
                sin8 = x8[7-k]; sin_valid8 = 1'b1;
                @(posedge clk); #1;
            end
            sin_valid8 = 1'b0;
            check("w8_valid", dout_valid8, 1);
            check("w8_dout", dout8, y8[v]);
            check("w8_err", dout_err8, e8[v]);
            @(posedge clk); #1;
            check("w8_done", dout_valid8, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
